// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops, WIDTH-step shift-add MUL and restoring DIVU/REMU.
// Latency 1 for simple ops, WIDTH+1 edges for MUL/DIV; the result is held while out_ready is low and then in_ready follows out_ready.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             busy
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNTW-1:0]  cnt;
    logic [1:0]       iop;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;

    logic [WIDTH-1:0] comb_res;
    logic [WIDTH-1:0] nacc;
    logic [WIDTH-1:0] nmq;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [SHW-1:0]   sh;
    logic             is_iter;
    logic             accept;

    assign sh        = b[SHW-1:0];
    assign is_iter   = (alu_sel[3:2] == 2'b10);
    assign busy      = (state == S_BUSY);
    assign out_valid = (state == S_DONE);
    assign in_ready  = rst_n && (state != S_BUSY) && ((state != S_DONE) || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        comb_res = '0;
        case (alu_sel)
            4'd0:    comb_res = a + b;
            4'd1:    comb_res = a - b;
            4'd2:    comb_res = ~a;
            4'd3:    comb_res = a << sh;
            4'd4:    comb_res = a >> sh;
            4'd5:    comb_res = a & b;
            4'd6:    comb_res = a | b;
            4'd7:    comb_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd12:   comb_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd13:   comb_res = $unsigned($signed(a) >>> sh);
            4'd14:   comb_res = a ^ b;
            4'd15:   comb_res = ~(a | b);
            default: comb_res = '0;
        endcase
    end

    // MUL: {acc,mq} is the product/multiplier pair shifted right each step.
    // DIV: acc is the partial remainder, mq shifts the dividend out and quotient bits in.
    always_comb begin
        sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        trial = {acc, mq[WIDTH-1]};
        nacc  = '0;
        nmq   = '0;
        if (iop[1]) begin
            if (trial >= {1'b0, opnd}) begin
                nacc = trial[WIDTH-1:0] - opnd;
                nmq  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                nacc = trial[WIDTH-1:0];
                nmq  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            nacc = sum[WIDTH:1];
            nmq  = {sum[0], mq[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            iop     <= '0;
            opnd    <= '0;
            acc     <= '0;
            mq      <= '0;
            alu_out <= '0;
            zero    <= 1'b1;
        end else if (state == S_BUSY) begin
            acc <= nacc;
            mq  <= nmq;
            cnt <= cnt - 1'b1;
            if (cnt == CNTW'(1)) begin
                // low half / quotient lands in mq, high half / remainder in acc
                alu_out <= iop[0] ? nacc : nmq;
                zero    <= ((iop[0] ? nacc : nmq) == '0);
                state   <= S_DONE;
            end
        end else if (accept) begin
            if (is_iter) begin
                iop   <= alu_sel[1:0];
                opnd  <= alu_sel[1] ? b : a;
                mq    <= alu_sel[1] ? a : b;
                acc   <= '0;
                cnt   <= CNTW'(WIDTH);
                state <= S_BUSY;
            end else begin
                alu_out <= comb_res;
                zero    <= (comb_res == '0);
                state   <= S_DONE;
            end
        end else if ((state == S_DONE) && out_ready) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         zero;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        int unsigned    s;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        s = y % W;
        case (op)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return ~x;
            4'd3:  return x << s;
            4'd4:  return x >> s;
            4'd5:  return x & y;
            4'd6:  return x | y;
            4'd7:  return (x < y) ? 1 : 0;
            4'd8:  return p[W-1:0];
            4'd9:  return p[2*W-1:W];
            4'd10: return (y == 0) ? {W{1'b1}} : x / y;
            4'd11: return (y == 0) ? x : x % y;
            4'd12: return ($signed(x) < $signed(y)) ? 1 : 0;
            4'd13: return $unsigned($signed(x) >>> s);
            4'd14: return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one op, confirm latency/result/zero, then complete the handshake.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [W-1:0] exp;
        int lat;
        int exp_lat;
        exp = ref_alu(op, x, y);
        // accept edge, plus WIDTH busy edges for MUL/DIV family
        exp_lat = (op[3:2] == 2'b10) ? W + 1 : 1;
        a = x; b = y; alu_sel = op; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; alu_sel = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, alu_out, exp);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_released"}, {31'b0, out_valid}, 0);
    endtask

    initial begin
        logic [W-1:0] held;
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; alu_sel = '0;
        @(posedge clk); #1;
        check("rst_in_ready_low", {31'b0, in_ready}, 0);
        @(posedge clk); #1;
        check("rst_alu_out", alu_out, 0);
        check("rst_zero", {31'b0, zero}, 1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 1);

        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        run_op(4'd8, 32'h0001_0000, 32'h0003_0000, "mul");
        run_op(4'd9, 32'h0001_0000, 32'h0003_0000, "mulhu");
        run_op(4'd10, 32'd100, 32'd7, "divu");
        run_op(4'd11, 32'd100, 32'd7, "remu");
        run_op(4'd10, 32'd5, 32'd0, "divu_by0");
        run_op(4'd11, 32'd5, 32'd0, "remu_by0");
        run_op(4'd12, 32'hFFFF_FFFF, 32'd1, "slt");
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1, "sltu");
        run_op(4'd13, 32'h8000_0000, 32'd31, "sra");
        run_op(4'd3, 32'h0000_0005, 32'd33, "sll_wrapamt");

        // busy flag and input blocking during an iterative op
        a = 32'd12345; b = 32'd678; alu_sel = 4'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mul_busy", {31'b0, busy}, 1);
        check("mul_in_ready_low", {31'b0, in_ready}, 0);
        while (!out_valid) begin @(posedge clk); #1; end
        check("mul_busy_result", alu_out, ref_alu(4'd8, 32'd12345, 32'd678));
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;

        // backpressure then back-to-back accept on the handshake edge
        a = 32'd40; b = 32'd2; alu_sel = 4'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        held = alu_out;
        check("bp_first", held, 32'd38);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_stable", alu_out, held);
            check("bp_in_ready", {31'b0, in_ready}, 0);
            check("bp_valid", {31'b0, out_valid}, 1);
        end
        a = 32'h0F0F_0000; b = 32'h00FF_FF00; alu_sel = 4'd14; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_valid", {31'b0, out_valid}, 1);
        check("b2b_result", alu_out, ref_alu(4'd14, 32'h0F0F_0000, 32'h00FF_FF00));
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;

        // reset in the middle of a divide
        a = 32'd1000; b = 32'd3; alu_sel = 4'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_valid", {31'b0, out_valid}, 0);
        check("mid_rst_out", alu_out, 0);
        check("mid_rst_zero", {31'b0, zero}, 1);
        check("mid_rst_in_ready", {31'b0, in_ready}, 0);
        rst_n = 1'b1;
        run_op(4'd0, 32'd2, 32'd3, "add_after_rst");

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom);
            ra  = $urandom;
            rb  = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            run_op(rop, ra, rb, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
